active_prefix_accum: RTL and testbench

Accumulates 4-bit low-entropy input symbols into the active prefix of the hybrid entropy coder and queries the combinational codebook stage with it. On a codebook match it latches the codeword and hands it downstream over a valid/ready interface, then clears the prefix. It also emits flush residuals at end of segment and flags prefix overflow. The block sits directly upstream of the codebook match stage and drives that stage's `ap_cnt_i` / `ap_data_i`.

---
 rtl/active_prefix_accum.sv | 148 ++++++++++++++
 tb/tb_active_prefix_accum.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/active_prefix_accum.sv
// Active-prefix accumulator for the hybrid entropy coder.
// Packs 4-bit symbols into a prefix, asks the external codebook for a
// match, and hands matched codewords or flush residuals downstream.
module active_prefix_accum #(
  parameter int CODEBOOK_LENGTH_MAX = 64,
  parameter int ENCODE_DATALENGTH   = 21,
  parameter int AP_CNT_MAX          = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sym_valid_i,
  input  logic [3:0]                     sym_i,
  output logic                           sym_ready_o,
  input  logic                           flush_i,
  output logic                           flush_done_o,
  output logic [5:0]                     ap_cnt_o,
  output logic [CODEBOOK_LENGTH_MAX-1:0] ap_data_o,
  input  logic                           cb_match_i,
  input  logic [5:0]                     cb_length_i,
  input  logic [ENCODE_DATALENGTH-1:0]   cb_data_i,
  output logic                           cw_valid_o,
  input  logic                           cw_ready_i,
  output logic [5:0]                     cw_length_o,
  output logic [ENCODE_DATALENGTH-1:0]   cw_data_o,
  output logic                           cw_flush_o,
  output logic                           err_overflow_o
);

  typedef enum logic [1:0] {ST_ACC, ST_CHECK, ST_EMIT} state_t;

  state_t                           r_state, w_state_nxt;
  logic [5:0]                       r_ap_cnt, w_ap_cnt_nxt;
  logic [CODEBOOK_LENGTH_MAX-1:0]   r_ap_data, w_ap_data_nxt;
  logic [5:0]                       r_cw_len, w_cw_len_nxt;
  logic [ENCODE_DATALENGTH-1:0]     r_cw_data, w_cw_data_nxt;
  logic                             r_cw_flush, w_cw_flush_nxt;
  logic                             r_flush_done, w_flush_done_nxt;
  logic                             r_err, w_err_nxt;

  logic [CODEBOOK_LENGTH_MAX-1:0]   w_ap_append;
  logic [ENCODE_DATALENGTH-1:0]     w_resid;
  logic [5:0]                       w_resid_len;

  // Newest symbol enters the LSB nibble; bits above 4*cnt stay zero
  // because the prefix is cleared before it can exceed AP_CNT_MAX symbols.
  assign w_ap_append = {r_ap_data[CODEBOOK_LENGTH_MAX-5:0], sym_i};
  assign w_resid_len = {r_ap_cnt[3:0], 2'b00};

  // Residual is the prefix right-aligned in the codeword field.
  if (ENCODE_DATALENGTH <= CODEBOOK_LENGTH_MAX) begin : g_resid_trunc
    assign w_resid = r_ap_data[ENCODE_DATALENGTH-1:0];
  end else begin : g_resid_ext
    assign w_resid = {{(ENCODE_DATALENGTH-CODEBOOK_LENGTH_MAX){1'b0}}, r_ap_data};
  end

  // Next-state and datapath update for the ACC/CHECK/EMIT sequence.
  always_comb begin
    w_state_nxt      = r_state;
    w_ap_cnt_nxt     = r_ap_cnt;
    w_ap_data_nxt    = r_ap_data;
    w_cw_len_nxt     = r_cw_len;
    w_cw_data_nxt    = r_cw_data;
    w_cw_flush_nxt   = r_cw_flush;
    w_flush_done_nxt = 1'b0;
    w_err_nxt        = r_err;
    case (r_state)
      ST_ACC: begin
        if (sym_valid_i) begin
          // A symbol always wins over a concurrent flush.
          w_ap_data_nxt = w_ap_append;
          w_ap_cnt_nxt  = r_ap_cnt + 6'd1;
          w_state_nxt   = ST_CHECK;
        end else if (flush_i && !r_flush_done) begin
          // The done pulse blocks re-triggering while the requester
          // is still dropping flush_i.
          if (r_ap_cnt != 6'd0) begin
            w_cw_len_nxt   = w_resid_len;
            w_cw_data_nxt  = w_resid;
            w_cw_flush_nxt = 1'b1;
            w_ap_cnt_nxt   = 6'd0;
            w_ap_data_nxt  = '0;
            w_state_nxt    = ST_EMIT;
          end else begin
            w_flush_done_nxt = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (cb_match_i) begin
          w_cw_len_nxt   = cb_length_i;
          w_cw_data_nxt  = cb_data_i;
          w_cw_flush_nxt = 1'b0;
          w_ap_cnt_nxt   = 6'd0;
          w_ap_data_nxt  = '0;
          w_state_nxt    = ST_EMIT;
        end else if (r_ap_cnt == 6'(AP_CNT_MAX)) begin
          w_err_nxt     = 1'b1;
          w_ap_cnt_nxt  = 6'd0;
          w_ap_data_nxt = '0;
          w_state_nxt   = ST_ACC;
        end else begin
          w_state_nxt = ST_ACC;
        end
      end
      ST_EMIT: begin
        if (cw_ready_i) begin
          w_flush_done_nxt = r_cw_flush;
          w_state_nxt      = ST_ACC;
        end
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // State and datapath registers; reset drops everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ACC;
      r_ap_cnt     <= 6'd0;
      r_ap_data    <= '0;
      r_cw_len     <= 6'd0;
      r_cw_data    <= '0;
      r_cw_flush   <= 1'b0;
      r_flush_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ap_cnt     <= w_ap_cnt_nxt;
      r_ap_data    <= w_ap_data_nxt;
      r_cw_len     <= w_cw_len_nxt;
      r_cw_data    <= w_cw_data_nxt;
      r_cw_flush   <= w_cw_flush_nxt;
      r_flush_done <= w_flush_done_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign sym_ready_o    = (r_state == ST_ACC);
  assign cw_valid_o     = (r_state == ST_EMIT);
  assign ap_cnt_o       = r_ap_cnt;
  assign ap_data_o      = r_ap_data;
  assign cw_length_o    = r_cw_len;
  assign cw_data_o      = r_cw_data;
  assign cw_flush_o     = r_cw_flush;
  assign flush_done_o   = r_flush_done;
  assign err_overflow_o = r_err;

endmodule

// File: tb/tb_active_prefix_accum.sv
// Scoreboard bench for active_prefix_accum with a small table codebook.
module tb_active_prefix_accum;
  localparam int CBL = 64;
  localparam int EDL = 21;
  localparam int APM = 5;

  localparam int CB_N = 4;
  localparam int          CB_CNT [CB_N] = '{1, 2, 3, 3};
  localparam logic [63:0] CB_KEY [CB_N] = '{64'hF, 64'h0F, 64'h44F, 64'h01F};
  localparam int          CB_LEN [CB_N] = '{5, 8, 12, 11};
  localparam logic [20:0] CB_CW  [CB_N] = '{21'h12, 21'hDE, 21'hFFE, 21'h7F6};

  logic           clk, rst_n;
  logic           sym_valid_i, sym_ready_o, flush_i, flush_done_o;
  logic [3:0]     sym_i;
  logic [5:0]     ap_cnt_o, cb_length_i, cw_length_o;
  logic [CBL-1:0] ap_data_o;
  logic           cb_match_i, cw_valid_o, cw_ready_i, cw_flush_o, err_overflow_o;
  logic [EDL-1:0] cb_data_i, cw_data_o;

  active_prefix_accum #(.CODEBOOK_LENGTH_MAX(CBL), .ENCODE_DATALENGTH(EDL), .AP_CNT_MAX(APM)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid_i(sym_valid_i), .sym_i(sym_i), .sym_ready_o(sym_ready_o),
    .flush_i(flush_i), .flush_done_o(flush_done_o), .ap_cnt_o(ap_cnt_o), .ap_data_o(ap_data_o),
    .cb_match_i(cb_match_i), .cb_length_i(cb_length_i), .cb_data_i(cb_data_i),
    .cw_valid_o(cw_valid_o), .cw_ready_i(cw_ready_i), .cw_length_o(cw_length_o),
    .cw_data_o(cw_data_o), .cw_flush_o(cw_flush_o), .err_overflow_o(err_overflow_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table codebook answering the DUT's prefix query.
  always_comb begin
    cb_match_i  = 1'b0;
    cb_length_i = 6'd0;
    cb_data_i   = '0;
    for (int i = 0; i < CB_N; i++)
      if (ap_cnt_o == 6'(CB_CNT[i]) && ap_data_o == CB_KEY[i]) begin
        cb_match_i  = 1'b1;
        cb_length_i = 6'(CB_LEN[i]);
        cb_data_i   = CB_CW[i];
      end
  end

  typedef struct { int len; logic [63:0] data; bit fl; } exp_t;
  exp_t expq[$];
  int   pfx[$];
  bit   m_err;
  int   exp_fd, got_fd;
  int   n_chk, n_err;
  int   rdy_mode;   // 0 always ready, 1 stalled, 2 random

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pfx_key();
    logic [63:0] k = 64'd0;
    foreach (pfx[i]) k = (k << 4) | 64'(pfx[i]);
    return k;
  endfunction

  // Reference: symbol list grows; a table hit emits the codeword,
  // a full list without a hit is discarded and flags overflow.
  task automatic model_sym(input int s);
    logic [63:0] k;
    int hit = -1;
    pfx.push_back(s);
    k = pfx_key();
    for (int i = 0; i < CB_N; i++)
      if (pfx.size() == CB_CNT[i] && k == CB_KEY[i]) hit = i;
    if (hit >= 0) begin
      expq.push_back('{len: CB_LEN[hit], data: 64'(CB_CW[hit]), fl: 1'b0});
      pfx.delete();
    end else if (pfx.size() == APM) begin
      m_err = 1'b1;
      pfx.delete();
    end
  endtask

  task automatic model_flush();
    if (pfx.size() > 0) begin
      expq.push_back('{len: 4 * pfx.size(), data: pfx_key(), fl: 1'b1});
      pfx.delete();
    end
    exp_fd++;
  endtask

  // Downstream ready generator.
  initial begin
    cw_ready_i = 1'b1;
    forever begin
      @(negedge clk); #1;
      case (rdy_mode)
        0:       cw_ready_i = 1'b1;
        1:       cw_ready_i = 1'b0;
        default: cw_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each codeword handshake.
  initial begin
    exp_t e;
    bit   prev_fd = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (flush_done_o) begin
        got_fd++;
        chk("flush_done_width", {63'd0, prev_fd}, 64'd0);
      end
      prev_fd = flush_done_o;
      if (rst_n && cw_valid_o && cw_ready_i) begin
        if (expq.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_cw: got len %0d data 0x%0h, none expected", cw_length_o, cw_data_o);
        end else begin
          e = expq.pop_front();
          chk("cw_length", 64'(cw_length_o), 64'(e.len));
          chk("cw_data", 64'(cw_data_o), e.data);
          chk("cw_flush", 64'(cw_flush_o), 64'(e.fl));
        end
      end
    end
  end

  task automatic send(input int s);
    int n = 0;
    sym_i = 4'(s);
    sym_valid_i = 1'b1;
    while (!sym_ready_o && n < 100) begin @(negedge clk); n++; end
    if (!sym_ready_o) begin
      sym_valid_i = 1'b0;
      chk("send_timeout", 64'd0, 64'd1);
      return;
    end
    @(posedge clk); #1;
    sym_valid_i = 1'b0;
    model_sym(s);
  endtask

  task automatic do_flush();
    int n = 0;
    model_flush();
    flush_i = 1'b1;
    do begin @(negedge clk); n++; end while (!flush_done_o && n < 200);
    flush_i = 1'b0;
    if (!flush_done_o) chk("flush_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < 500) begin
      @(negedge clk); n++;
      if (expq.size() == 0 && sym_ready_o && !cw_valid_o) quiet++; else quiet = 0;
    end
    if (quiet < 3) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int fd0, n;
    logic [63:0] hold_d, hold_l;
    int syms [6] = '{0, 1, 4, 7, 15, 15};
    rst_n = 1'b0; sym_valid_i = 1'b0; sym_i = 4'd0; flush_i = 1'b0;
    rdy_mode = 0; m_err = 1'b0; exp_fd = 0; got_fd = 0; n_chk = 0; n_err = 0;
    repeat (3) @(negedge clk);
    chk("rst_ap_cnt", 64'(ap_cnt_o), 64'd0);
    chk("rst_ap_data", ap_data_o, 64'd0);
    chk("rst_cw_valid", 64'(cw_valid_o), 64'd0);
    chk("rst_cw_len", 64'(cw_length_o), 64'd0);
    chk("rst_cw_data", 64'(cw_data_o), 64'd0);
    chk("rst_err", 64'(err_overflow_o), 64'd0);
    chk("rst_flush_done", 64'(flush_done_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sym_ready", 64'(sym_ready_o), 64'd1);

    // Single escape with latency
    send(15);
    @(negedge clk);
    chk("lat_k1_valid", 64'(cw_valid_o), 64'd0);
    chk("lat_k1_sym_ready", 64'(sym_ready_o), 64'd0);
    @(negedge clk);
    chk("lat_k2_valid", 64'(cw_valid_o), 64'd1);
    chk("lat_k2_ap_cnt", 64'(ap_cnt_o), 64'd0);
    wait_idle();

    // Multi-symbol codes
    send(0); send(15); wait_idle();
    send(4); send(4); send(15); wait_idle();
    send(0); send(1); send(15); wait_idle();
    chk("codes_ap_cnt", 64'(ap_cnt_o), 64'd0);

    // Backpressure
    rdy_mode = 1;
    @(negedge clk); @(negedge clk);
    send(15);
    n = 0;
    while (!cw_valid_o && n < 20) begin @(negedge clk); n++; end
    chk("bp_valid", 64'(cw_valid_o), 64'd1);
    hold_d = 64'(cw_data_o);
    hold_l = 64'(cw_length_o);
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_valid", 64'(cw_valid_o), 64'd1);
      chk("bp_hold_data", 64'(cw_data_o), hold_d);
      chk("bp_hold_len", 64'(cw_length_o), hold_l);
      chk("bp_sym_ready", 64'(sym_ready_o), 64'd0);
      if (c < 2) @(negedge clk);
    end
    rdy_mode = 0;
    wait_idle();

    // Flush with residual, then with empty prefix
    fd0 = got_fd;
    send(7); do_flush(); wait_idle();
    chk("flush_resid_done_cnt", 64'(got_fd - fd0), 64'd1);
    fd0 = got_fd;
    do_flush(); wait_idle();
    chk("flush_empty_done_cnt", 64'(got_fd - fd0), 64'd1);

    // Overflow
    for (int i = 0; i < 5; i++) send(1);
    wait_idle();
    chk("ovf_err", 64'(err_overflow_o), 64'(m_err));
    chk("ovf_ap_cnt", 64'(ap_cnt_o), 64'd0);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", 64'(err_overflow_o), 64'd1);

    // Reset mid-prefix
    send(4); send(4);
    @(negedge clk);
    chk("mid_ap_cnt_pre", 64'(ap_cnt_o), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ap_cnt", 64'(ap_cnt_o), 64'd0);
    chk("mid_rst_ap_data", ap_data_o, 64'd0);
    chk("mid_rst_cw_valid", 64'(cw_valid_o), 64'd0);
    chk("mid_rst_cw_len", 64'(cw_length_o), 64'd0);
    chk("mid_rst_cw_data", 64'(cw_data_o), 64'd0);
    chk("mid_rst_cw_flush", 64'(cw_flush_o), 64'd0);
    chk("mid_rst_err", 64'(err_overflow_o), 64'd0);
    pfx.delete(); m_err = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    send(15); wait_idle();

    // Randomized traffic with random downstream stalls
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 12) do_flush();
      else send(syms[$urandom_range(0, 5)]);
    end
    do_flush();
    rdy_mode = 0;
    wait_idle();
    chk("final_err", 64'(err_overflow_o), 64'(m_err));
    chk("final_fd_count", 64'(got_fd), 64'(exp_fd));
    chk("final_queue_empty", 64'(expq.size()), 64'd0);
    chk("final_ap_cnt", 64'(ap_cnt_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
